// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and helpers for the parametrised UART receiver.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Receiver frame-tracking states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Total bits on the wire for one frame: start + data + optional parity + stop
  function automatic int frame_bits(input int data_bits, input int parity_mode,
                                    input int stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_filter.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_filter
// Brief    : 2-FF synchroniser plus saturating up/down glitch filter, both
//            advanced on the oversampling tick.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_filter #(
  parameter int FILT_W = 2
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic baud_tick,
  input  logic rx,
  output logic rx_filt
);

  localparam logic [FILT_W-1:0] CNT_MAX = '1;

  logic [1:0]        r_sync;
  logic [FILT_W-1:0] r_cnt;

  // Bring the asynchronous line into the clock domain; reset to idle-high
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
    end else if (baud_tick) begin
      r_sync <= {r_sync[0], rx};
    end
  end

  // Saturating counter integrates the synchronised line level
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= CNT_MAX;
    end else if (baud_tick) begin
      if (r_sync[1] && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + FILT_W'(1);
      end else if (!r_sync[1] && (r_cnt != '0)) begin
        r_cnt <= r_cnt - FILT_W'(1);
      end
    end
  end

  // Hysteresis: output flips only at the counter extremes
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_filt <= 1'b1;
    end else if (r_cnt == CNT_MAX) begin
      rx_filt <= 1'b1;
    end else if (r_cnt == '0) begin
      rx_filt <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised oversampling UART receiver with parity, framing and
//            break status, a valid/ready holding register and overrun pulse.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FILT_W      = 2,
  parameter int WDOG_W      = 12
) (
  input  logic                 sysclk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 break_det,
  output logic                 overrun
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // --------------------------------------------------------------------------
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_rx_param: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $fatal(1, "uart_rx_param: OVERSAMPLE must be even, 8..32");
  end
  if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_EVEN) begin : g_bad_parity
    $fatal(1, "uart_rx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (FILT_W < 1) begin : g_bad_filt
    $fatal(1, "uart_rx_param: FILT_W must be at least 1");
  end
  // The watchdog must never trip on a legitimate frame
  if (WDOG_W < 2 || WDOG_W > 31 ||
      frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS) * OVERSAMPLE >= (1 << (WDOG_W - 1)))
  begin : g_bad_wdog
    $fatal(1, "uart_rx_param: WDOG_W too small for one frame, or out of range");
  end

  localparam int                SCNT_W      = $clog2(OVERSAMPLE);
  localparam logic [SCNT_W-1:0] SAMPLE_PT   = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SAMPLE_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]        LAST_DATA   = 4'(DATA_BITS - 1);
  localparam logic [3:0]        LAST_STOP   = 4'(STOP_BITS - 1);

  rx_state_t            r_state;
  logic [SCNT_W-1:0]    r_sample_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic                 r_brk;
  logic [WDOG_W-1:0]    r_wdog;

  logic w_rx_filt;
  logic w_sample;
  logic w_abort;
  logic w_last_stop;
  logic w_stop_frm;
  logic w_stop_brk;
  logic w_complete;

  uart_rx_filter #(
    .FILT_W (FILT_W)
  ) u_filter (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_filt   (w_rx_filt)
  );

  assign w_sample    = baud_tick && (r_sample_cnt == SAMPLE_PT);
  assign w_abort     = r_wdog[WDOG_W-1];
  assign w_last_stop = (r_bit_cnt == LAST_STOP);
  // Status as it will stand once the current stop sample is absorbed
  assign w_stop_frm  = r_frm_err | ~w_rx_filt;
  assign w_stop_brk  = (r_bit_cnt == 4'd0) ? ((~|r_shift) & ~w_rx_filt) : r_brk;
  assign w_complete  = !w_abort && (r_state == ST_STOP) && w_sample && w_last_stop;

  // Bit-phase and watchdog counters run only while a frame is in progress
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample_cnt <= '0;
      r_wdog       <= '0;
    end else if (r_state == ST_IDLE) begin
      r_sample_cnt <= '0;
      r_wdog       <= '0;
    end else if (baud_tick) begin
      r_sample_cnt <= (r_sample_cnt == SAMPLE_LAST) ? '0 : r_sample_cnt + SCNT_W'(1);
      r_wdog       <= r_wdog + WDOG_W'(1);
    end
  end

  // Frame state machine: samples each bit at its midpoint
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_brk     <= 1'b0;
    end else if (w_abort) begin
      r_state <= ST_IDLE;
    end else if (baud_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_filt) begin
            r_state   <= ST_START;
            r_bit_cnt <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_brk     <= 1'b0;
          end
        end
        ST_START: begin
          if (w_sample) begin
            r_state <= w_rx_filt ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_sample) begin
            r_shift <= {w_rx_filt, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_sample) begin
            // Error when the overall XOR disagrees with the selected sense
            r_par_err <= (^r_shift) ^ w_rx_filt ^ (PARITY_MODE == PARITY_ODD);
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_sample) begin
            r_frm_err <= w_stop_frm;
            r_brk     <= w_stop_brk;
            if (w_last_stop) begin
              r_state <= w_stop_brk ? ST_BRK_WAIT : ST_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        ST_BRK_WAIT: begin
          if (w_rx_filt) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register with valid/ready handshake and overrun pulse
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      break_det   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_complete) begin
        if (!data_valid || data_ready) begin
          data_out    <= r_shift;
          parity_err  <= r_par_err;
          framing_err <= w_stop_frm;
          break_det   <= w_stop_brk;
          data_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
